occupancy_tracker: RTL and testbench
====================================

# occupancy_tracker

Clocked, parametrised occupancy monitor for a building of nested zones fed by multiple doors. Each accepted sample carries per-door, per-zone enter/exit counts. The block accumulates registered zone occupancies and checks three invariants: no underflow, no overflow, and inner zones never exceeding their enclosing zone. A violating sample is rejected with a fault report, and the last good counts are held. It sits between the door-event aggregators and the supervisory controller, with a valid/ready handshake on both sides.

## Interface
- NDOORS, 3, number of doors (≥1)
- NZONES, 2, number of nested zones (≥2); zone z+1 lies inside zone z
- WORDLEN, 10, width of one count word
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  sample present
- in_ready  out  1  block can accept the sample
- in_events  in  2*WORDLEN*NZONES*NDOORS  slot k=d*NZONES+z occupies bits [2*WORDLEN*(k+1)-1 : 2*WORDLEN*k]; upper WORDLEN = entered, lower WORDLEN = exited
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- out_counts  out  NZONES*WORDLEN  committed occupancy; zone 0 in LSBs
- commit  out  1  result's sample was applied
- fault  out  1  fault indication (see Configuration)
- fault_kind  out  2  01 underflow, 10 overflow, 11 nesting, 00 none
- fault_zone  out  max(1,$clog2(NZONES))  zone of the reported fault
- clr_fault  in  1  clears a sticky fault

## Operation
- Accept on in_valid && in_ready. in_ready = !out_valid || out_ready.
- Per zone: next[z] = cnt[z] + Σd entered[d][z] − Σd exited[d][z]. Compute in signed arithmetic WORDLEN+$clog2(NDOORS)+2 bits wide, with no intermediate wrap.
- Checks use the unwrapped next values:
  - underflow: next[z] < 0
  - overflow: next[z] > 2^WORDLEN−1
  - nesting: next[z] < next[z+1] for z in 0..NZONES−2, reported as zone z+1
- Priority: underflow over overflow over nesting. Within a kind, the lowest zone index wins.
- No violation: cnt ← next, commit=1, fault_kind=00.
- Any violation: cnt unchanged, commit=0, fault_kind and fault_zone set per the priority rule.
- An all-zero sample is legal: commit=1, counts unchanged.

## Timing
- Latency 1: a sample accepted on edge N is visible on out_* after edge N; out_valid=1 from then.
- Output register holds while out_valid && !out_ready. in_ready is low during that time.
- Simultaneous out_ready and new accept: the new result replaces the old one on the same edge, with no bubble. Full throughput is one sample per cycle.
- out_counts always equals the committed cnt. It changes only on an accepting edge.
- Reset values: out_valid=0, out_counts=0, commit=0, fault=0, fault_kind=00, fault_zone=0. in_ready=1 after reset.
- Reset asserted mid-stream drops any pending result. The sample on the reset edge is not accepted.

## Configuration
- OCCMON_STICKY_FAULT_EN defined:
  - fault sets on any violating sample and holds until a clr_fault cycle.
  - clr_fault on the same edge as a new violation leaves fault=1 (set wins).
  - fault_kind/fault_zone keep the first fault's values until cleared. Later clean samples still commit.
- OCCMON_STICKY_FAULT_EN not defined:
  - fault = (fault_kind != 00) of the current result.
  - fault_kind/fault_zone describe the current result only.
  - clr_fault is ignored.

## Test plan
(NDOORS=3, NZONES=2, WORDLEN=10 unless noted)
- Reset, then door0 enters A=5, B=3 -> next cycle out_valid=1, out_counts={B=3,A=5}, commit=1, fault=0.
- From A=5,B=3: door1 exits A=4 -> A=1<B=3 nesting fault: fault_kind=11, fault_zone=1, counts stay {3,5}, commit=0.
- From A=0,B=0: door2 exits B=1 -> underflow, fault_kind=01, fault_zone=1. From A=1020,B=0: 3 doors enter A=2 each (sum 1026) -> overflow, fault_kind=10, fault_zone=0, counts held.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* stable. Then out_ready=1 -> accept on that edge, one sample per cycle thereafter.
- Sticky mode: fault, then a clean sample -> fault stays 1 and counts update. Pulse clr_fault -> fault=0 next edge. Non-sticky build, same stimulus -> fault drops with the clean sample.
- Assert rst_n low while out_valid=1 and counts nonzero -> all outputs return to reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/occupancy_tracker.sv
// occupancy_tracker
//
// Keeps a registered occupancy count for a stack of nested zones fed by
// several doors. Each accepted sample carries, for every (door, zone) pair,
// an entered count and an exited count. The block forms the next occupancy
// of every zone at full precision, then checks three invariants: no zone
// goes negative, no zone exceeds the count word, and an inner zone never
// holds more people than the zone enclosing it. A clean sample is
// committed. A violating sample leaves the counts untouched and is reported.
//
// Optional feature macro: OCCMON_STICKY_FAULT_EN
//   defined   : fault/fault_kind/fault_zone latch the first violation and
//               hold it until clr_fault (a violation on the same edge wins).
//   undefined : fault/fault_kind/fault_zone describe the current result;
//               clr_fault is ignored.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid && ready. in_ready = !out_valid || out_ready, so the single output
// register is refilled on the same edge it is drained (no bubble).
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  sample handshake
//   in_events       slot k = d*NZONES+z at [2*WORDLEN*(k+1)-1 : 2*WORDLEN*k],
//                   upper WORDLEN = entered, lower WORDLEN = exited
//   out_valid/ready result handshake
//   out_counts      committed occupancy, zone 0 in the LSBs
//   commit          the result's sample was applied
//   fault           fault indication (mode depends on the macro above)
//   fault_kind      01 underflow, 10 overflow, 11 nesting, 00 none
//   fault_zone      zone of the reported fault
//   clr_fault       clears a sticky fault
module occupancy_tracker #(
  parameter int NDOORS  = 3,
  parameter int NZONES  = 2,
  parameter int WORDLEN = 10,
  localparam int ZW     = (NZONES > 1) ? $clog2(NZONES) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [2*WORDLEN*NZONES*NDOORS-1:0] in_events,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NZONES*WORDLEN-1:0]          out_counts,
  output logic                               commit,
  output logic                               fault,
  output logic [1:0]                         fault_kind,
  output logic [ZW-1:0]                      fault_zone,
  input  logic                               clr_fault
);

  // Wide enough that cnt + NDOORS*max_entered and 0 - NDOORS*max_exited
  // both fit without wrapping, plus a sign bit.
  localparam int SW  = WORDLEN + $clog2(NDOORS) + 2;
  localparam int PAD = SW - WORDLEN;
  localparam logic signed [SW-1:0] MAX_CNT = $signed({{PAD{1'b0}}, {WORDLEN{1'b1}}});

  localparam logic [1:0] KIND_NONE  = 2'b00;
  localparam logic [1:0] KIND_UNDER = 2'b01;
  localparam logic [1:0] KIND_OVER  = 2'b10;
  localparam logic [1:0] KIND_NEST  = 2'b11;

  logic [NZONES*WORDLEN-1:0] cnt_q;
  logic signed [SW-1:0]      nxt [NZONES];
  logic [NZONES*WORDLEN-1:0] nxt_cnt;
  logic [1:0]                v_kind;
  logic [ZW-1:0]             v_zone;
  logic                      viol;
  logic                      accept;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign out_counts = cnt_q;

  // Unwrapped next occupancy per zone.
  always_comb begin
    nxt_cnt = '0;
    for (int z = 0; z < NZONES; z++) begin
      nxt[z] = $signed({{PAD{1'b0}}, cnt_q[z*WORDLEN +: WORDLEN]});
      for (int d = 0; d < NDOORS; d++) begin
        nxt[z] = nxt[z]
               + $signed({{PAD{1'b0}}, in_events[(2*(d*NZONES+z)+1)*WORDLEN +: WORDLEN]})
               - $signed({{PAD{1'b0}}, in_events[(2*(d*NZONES+z))*WORDLEN +: WORDLEN]});
      end
      nxt_cnt[z*WORDLEN +: WORDLEN] = nxt[z][WORDLEN-1:0];
    end
  end

  // Fault classification. Each kind is scanned from the highest zone down
  // so the lowest zone overwrites last; kinds are scanned from lowest to
  // highest priority so underflow overwrites overflow overwrites nesting.
  always_comb begin
    v_kind = KIND_NONE;
    v_zone = '0;
    for (int z = NZONES - 2; z >= 0; z--) begin
      if (nxt[z] < nxt[z+1]) begin
        v_kind = KIND_NEST;
        v_zone = ZW'(z + 1);
      end
    end
    for (int z = NZONES - 1; z >= 0; z--) begin
      if (nxt[z] > MAX_CNT) begin
        v_kind = KIND_OVER;
        v_zone = ZW'(z);
      end
    end
    for (int z = NZONES - 1; z >= 0; z--) begin
      if (nxt[z][SW-1]) begin
        v_kind = KIND_UNDER;
        v_zone = ZW'(z);
      end
    end
    viol = (v_kind != KIND_NONE);
  end

  // Committed counts and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      out_valid <= 1'b0;
      commit    <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        commit    <= !viol;
        if (!viol) cnt_q <= nxt_cnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef OCCMON_STICKY_FAULT_EN
  logic          sticky_q;
  logic [1:0]    kind_q;
  logic [ZW-1:0] zone_q;

  // The first violation since the last clear is kept. When a clear and a
  // violation share an edge, the violation becomes the new first fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      kind_q   <= KIND_NONE;
      zone_q   <= '0;
    end else if (accept && viol) begin
      sticky_q <= 1'b1;
      if (!sticky_q || clr_fault) begin
        kind_q <= v_kind;
        zone_q <= v_zone;
      end
    end else if (clr_fault) begin
      sticky_q <= 1'b0;
      kind_q   <= KIND_NONE;
      zone_q   <= '0;
    end
  end

  assign fault      = sticky_q;
  assign fault_kind = kind_q;
  assign fault_zone = zone_q;
`else
  logic [1:0]    res_kind_q;
  logic [ZW-1:0] res_zone_q;
  logic          unused_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_kind_q <= KIND_NONE;
      res_zone_q <= '0;
    end else if (accept) begin
      res_kind_q <= v_kind;
      res_zone_q <= v_zone;
    end
  end

  assign unused_clr = clr_fault;
  assign fault      = (res_kind_q != KIND_NONE);
  assign fault_kind = res_kind_q;
  assign fault_zone = res_zone_q;
`endif

endmodule

// File: tb/tb_occupancy_tracker.sv
// Bench for occupancy_tracker: directed scenarios followed by random traffic,
// checked by a scoreboard fed from a reference model of the occupancy rules.
module tb_occupancy_tracker;
  localparam int NDOORS  = 3;
  localparam int NZONES  = 2;
  localparam int WORDLEN = 10;
  localparam int ZW      = (NZONES > 1) ? $clog2(NZONES) : 1;
  localparam int EVW     = 2 * WORDLEN * NZONES * NDOORS;
  localparam int CW      = NZONES * WORDLEN;
  localparam int EW      = CW + 1 + 2 + ZW;
  localparam int MAXV    = 2 ** WORDLEN - 1;
`ifdef OCCMON_STICKY_FAULT_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [EVW-1:0] in_events = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [CW-1:0]  out_counts;
  logic           commit;
  logic           fault;
  logic [1:0]     fault_kind;
  logic [ZW-1:0]  fault_zone;
  logic           clr_fault = 1'b0;

  always #5 clk = ~clk;

  occupancy_tracker #(.NDOORS(NDOORS), .NZONES(NZONES), .WORDLEN(WORDLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_events(in_events),
    .out_valid(out_valid), .out_ready(out_ready), .out_counts(out_counts),
    .commit(commit), .fault(fault), .fault_kind(fault_kind), .fault_zone(fault_zone),
    .clr_fault(clr_fault)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];  // {counts, commit, kind, zone}
  int checks = 0;
  int errors = 0;
  int model_cnt[NZONES];
  logic          sf = 1'b0;
  logic [1:0]    sk = 2'b00;
  logic [ZW-1:0] sz = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [EVW-1:0] mk(input int d, input int z, input int ent, input int ext);
    logic [EVW-1:0] ev;
    int k;
    ev = '0;
    k = d * NZONES + z;
    ev[2*WORDLEN*k +: WORDLEN]           = WORDLEN'(ext);
    ev[2*WORDLEN*k + WORDLEN +: WORDLEN] = WORDLEN'(ent);
    return ev;
  endfunction

  function automatic int field(input logic [EVW-1:0] ev, input int d, input int z, input bit ent);
    logic [EVW-1:0] sh;
    sh = ev >> (2 * WORDLEN * (d * NZONES + z) + (ent ? WORDLEN : 0));
    return int'(sh[WORDLEN-1:0]);
  endfunction

  function automatic logic [CW-1:0] model_counts();
    logic [CW-1:0] cv;
    cv = '0;
    for (int z = 0; z < NZONES; z++) cv[z*WORDLEN +: WORDLEN] = WORDLEN'(model_cnt[z]);
    return cv;
  endfunction

  // Reference model: occupancy rules with plain integer arithmetic.
  task automatic model_step(input logic acc, input logic [EVW-1:0] ev, input logic clr);
    int nx[NZONES];
    int kind;
    int zone;
    kind = 0;
    zone = 0;
    if (acc) begin
      for (int z = 0; z < NZONES; z++) begin
        nx[z] = model_cnt[z];
        for (int d = 0; d < NDOORS; d++) nx[z] += field(ev, d, z, 1'b1) - field(ev, d, z, 1'b0);
      end
      for (int z = 0; z < NZONES; z++)
        if (kind == 0 && nx[z] < 0) begin kind = 1; zone = z; end
      for (int z = 0; z < NZONES; z++)
        if (kind == 0 && nx[z] > MAXV) begin kind = 2; zone = z; end
      for (int z = 1; z < NZONES; z++)
        if (kind == 0 && nx[z-1] < nx[z]) begin kind = 3; zone = z; end
      if (kind == 0) for (int z = 0; z < NZONES; z++) model_cnt[z] = nx[z];
      exp_q.push_back({model_counts(), (kind == 0), 2'(kind), ZW'(zone)});
    end
    if (acc && kind != 0) begin
      if (!sf || clr) begin sk = 2'(kind); sz = ZW'(zone); end
      sf = 1'b1;
    end else if (clr) begin
      sf = 1'b0; sk = 2'b00; sz = '0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int z = 0; z < NZONES; z++) model_cnt[z] = 0;
    sf = 1'b0; sk = 2'b00; sz = '0;
  endtask

  // Tracker: records each accepted sample and feeds the model.
  initial begin
    logic           acc;
    logic [EVW-1:0] ev;
    logic           clr;
    forever begin
      @(negedge clk);
      acc = in_valid && in_ready && rst_n;
      ev  = in_events;
      clr = clr_fault;
      @(posedge clk);
      if (rst_n) model_step(acc, ev, clr);
    end
  end

  // Monitor: compares presented results against the expected queue.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("out_valid", out_valid, exp_q.size() != 0);
        chk("in_ready", in_ready, (exp_q.size() == 0) || out_ready);
        chk("out_counts_committed", out_counts, model_counts());
        if (out_valid && exp_q.size() != 0) begin
          e = exp_q[0];
          chk("res_counts", out_counts, e[EW-1 -: CW]);
          chk("res_commit", commit, e[ZW+2]);
          if (!STICKY) begin
            chk("res_kind", fault_kind, e[ZW+1:ZW]);
            chk("res_zone", fault_zone, e[ZW-1:0]);
            chk("res_fault", fault, e[ZW+1:ZW] != 2'b00);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
        if (STICKY) begin
          chk("sticky_fault", fault, sf);
          chk("sticky_kind", fault_kind, sk);
          chk("sticky_zone", fault_zone, sz);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [EVW-1:0] ev, input logic ordy, input logic clr);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_events = ev;
    out_ready = ordy;
    clr_fault = clr;
  endtask

  task automatic step(input string nm, input logic [EVW-1:0] ev, input logic clr,
                      input logic [CW-1:0] e_cnt, input logic e_commit,
                      input logic [1:0] e_kind, input logic [ZW-1:0] e_zone, input logic e_fault);
    drive(1'b1, ev, 1'b1, clr);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_events = '0;
    clr_fault = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk({nm, "_counts"}, out_counts, e_cnt);
    chk({nm, "_commit"}, commit, e_commit);
    chk({nm, "_kind"}, fault_kind, e_kind);
    chk({nm, "_zone"}, fault_zone, e_zone);
    chk({nm, "_fault"}, fault, e_fault);
  endtask

  function automatic logic [EVW-1:0] rand_ev();
    logic [EVW-1:0] ev;
    ev = '0;
    if ($urandom_range(0, 9) == 0) return ev;
    for (int d = 0; d < NDOORS; d++)
      for (int z = 0; z < NZONES; z++)
        ev |= mk(d, z,
                 ($urandom_range(0, 15) == 0) ? $urandom_range(0, MAXV) : $urandom_range(0, 3),
                 ($urandom_range(0, 15) == 0) ? $urandom_range(0, MAXV) : $urandom_range(0, 2));
    return ev;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_counts", out_counts, '0);
    chk("rst_commit", commit, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_kind", fault_kind, 2'b00);
    chk("rst_zone", fault_zone, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // clr_fault rides along with each violating/clean directed sample, so
    // sticky and non-sticky builds present the same reports here.
    step("enter", mk(0, 0, 5, 0) | mk(0, 1, 3, 0), 1'b1, {10'd3, 10'd5}, 1'b1, 2'b00, 1'b0, 1'b0);
    step("nest", mk(1, 0, 0, 4), 1'b1, {10'd3, 10'd5}, 1'b0, 2'b11, 1'b1, 1'b1);
    step("empty", mk(0, 0, 0, 5) | mk(0, 1, 0, 3), 1'b1, {10'd0, 10'd0}, 1'b1, 2'b00, 1'b0, 1'b0);
    step("under", mk(2, 1, 0, 1), 1'b1, {10'd0, 10'd0}, 1'b0, 2'b01, 1'b1, 1'b1);
    step("fill", mk(0, 0, 1020, 0), 1'b1, {10'd0, 10'd1020}, 1'b1, 2'b00, 1'b0, 1'b0);
    step("over", mk(0, 0, 2, 0) | mk(1, 0, 2, 0) | mk(2, 0, 2, 0), 1'b1,
         {10'd0, 10'd1020}, 1'b0, 2'b10, 1'b0, 1'b1);
    step("clean_after_fault", mk(0, 0, 1, 0), 1'b0, {10'd0, 10'd1021}, 1'b1,
         STICKY ? 2'b10 : 2'b00, 1'b0, STICKY);
    step("zero_sample", '0, 1'b0, {10'd0, 10'd1021}, 1'b1,
         STICKY ? 2'b10 : 2'b00, 1'b0, STICKY);
    drive(1'b0, '0, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("clr_fault", fault, 1'b0);

    // Backpressure: one accept, then the result is held for three cycles.
    drive(1'b1, mk(0, 0, 1, 0) | mk(0, 1, 1, 0), 1'b0, 1'b0);
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_counts", out_counts, {10'd1, 10'd1022});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("tp_in_ready", in_ready, 1'b1);
    end

    // Reset asserted mid-cycle while a result is pending.
    drive(1'b1, '0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", out_valid, 1'b1);
    chk("pre_rst_nonzero", out_counts != '0, 1'b1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_counts", out_counts, '0);
    chk("arst_commit", commit, 1'b0);
    chk("arst_fault", fault, 1'b0);
    chk("arst_kind", fault_kind, 2'b00);
    chk("arst_zone", fault_zone, '0);
    chk("arst_in_ready", in_ready, 1'b1);
    model_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Random traffic.
    repeat (3000) begin
      drive($urandom_range(0, 3) != 0, rand_ev(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0);
    end

    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
